// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives the combinational ROM
// address, and captures {word, pc} pairs into a 2-entry buffer that feeds
// the decoder over a valid/ready handshake. Redirects reload the PC and
// flush the buffer.
module instr_fetch_ctrl #(
  parameter int                   BITS_DATA = 32,
  parameter int                   BITS_ADDR = 5,
  parameter logic [BITS_ADDR-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fetch_en,
  input  logic                 redirect_valid,
  input  logic [BITS_ADDR-1:0] redirect_addr,
  output logic [BITS_ADDR-1:0] rom_addr,
  input  logic [BITS_DATA-1:0] rom_data,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [BITS_DATA-1:0] instr,
  output logic [BITS_ADDR-1:0] instr_pc
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [BITS_ADDR-1:0] PC_ONE = {{(BITS_ADDR-1){1'b0}}, 1'b1};

  logic [0:0]           state;
  logic [BITS_ADDR-1:0] pc;
  logic [1:0]           count;
  logic [BITS_DATA-1:0] head_data;
  logic [BITS_ADDR-1:0] head_pc;
  logic [BITS_DATA-1:0] tail_data;
  logic [BITS_ADDR-1:0] tail_pc;
  logic                 pop;
  logic                 capture;

  // A redirect cancels both the pop and the capture of its cycle
  assign pop     = instr_valid & instr_ready & ~redirect_valid;
  assign capture = (state == RUN) & ~redirect_valid & ((count < 2'd2) | pop);

  assign rom_addr    = pc;
  assign instr_valid = (count != 2'd0);
  assign instr       = head_data;
  assign instr_pc    = head_pc;

  // Run/idle follows the sampled fetch enable; redirects do not affect it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= fetch_en ? RUN : IDLE;
  end

  // Program counter: redirect wins, otherwise advance (wrapping) on capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_addr;
    else if (capture)        pc <= pc + PC_ONE;
  end

  // Occupancy tracks captures in and pops out; flushed to empty on redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
    end else if (redirect_valid) begin
      count <= 2'd0;
    end else begin
      case ({capture, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Two-slot buffer: head shifts from tail on pop, new word lands in the
  // first free slot after the pop is accounted for
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data <= '0;
      head_pc   <= '0;
      tail_data <= '0;
      tail_pc   <= '0;
    end else if (redirect_valid) begin
      head_data <= '0;
      head_pc   <= '0;
      tail_data <= '0;
      tail_pc   <= '0;
    end else begin
      if (pop && count == 2'd2) begin
        head_data <= tail_data;
        head_pc   <= tail_pc;
      end
      if (capture) begin
        if (count == 2'd0 || (count == 2'd1 && pop)) begin
          head_data <= rom_data;
          head_pc   <= pc;
        end else begin
          tail_data <= rom_data;
          tail_pc   <= pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a
// queue-based model of the fetch stream.
module tb_instr_fetch_ctrl;

  localparam int BITS_DATA = 32;
  localparam int BITS_ADDR = 5;

  typedef struct packed {
    logic [BITS_DATA-1:0] data;
    logic [BITS_ADDR-1:0] pc;
  } entry_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 fetch_en = 1'b0;
  logic                 redirect_valid = 1'b0;
  logic [BITS_ADDR-1:0] redirect_addr = '0;
  logic [BITS_ADDR-1:0] rom_addr;
  logic [BITS_DATA-1:0] rom_data;
  logic                 instr_valid;
  logic                 instr_ready = 1'b0;
  logic [BITS_DATA-1:0] instr;
  logic [BITS_ADDR-1:0] instr_pc;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Reference model state
  entry_t               mq[$];
  logic [BITS_ADDR-1:0] mpc = '0;
  bit                   mrun = 1'b0;

  instr_fetch_ctrl #(
    .BITS_DATA(BITS_DATA),
    .BITS_ADDR(BITS_ADDR),
    .RESET_PC ('0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc)
  );

  // Program ROM: word[i] = i + 0x100
  assign rom_data = 32'h100 + {{(BITS_DATA-BITS_ADDR){1'b0}}, rom_addr};

  always #5 clk = ~clk;

  function automatic logic [BITS_DATA-1:0] romWord(input logic [BITS_ADDR-1:0] a);
    return 32'h100 + {{(BITS_DATA-BITS_ADDR){1'b0}}, a};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit fe, input bit rv, input logic [BITS_ADDR-1:0] ra, input bit rdy);
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_addr  = ra;
    instr_ready    = rdy;
  endtask

  task automatic waitNeg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkHead(input string tag, input logic [BITS_DATA-1:0] d, input logic [BITS_ADDR-1:0] p);
    checkOutput({tag, "_valid"}, 64'(instr_valid), 64'(1'b1));
    checkOutput({tag, "_instr"}, 64'(instr), 64'(d));
    checkOutput({tag, "_pc"}, 64'(instr_pc), 64'(p));
  endtask

  // Model: the fetch stream is a queue; each edge pops the front if the
  // decoder took it, then appends the word at the PC if there is room
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        mpc  = '0;
        mrun = 1'b0;
      end else begin
        if (redirect_valid) begin
          mq.delete();
          mpc = redirect_addr;
        end else begin
          bit do_pop;
          bit do_cap;
          do_pop = (mq.size() != 0) && instr_ready;
          do_cap = mrun && ((mq.size() < 2) || do_pop);
          if (do_pop) void'(mq.pop_front());
          if (do_cap) begin
            mq.push_back('{data: romWord(mpc), pc: mpc});
            mpc = mpc + 1'b1;
          end
        end
        mrun = fetch_en;
      end
    end
  end

  // Compare process: every cycle, outputs against the model
  always @(negedge clk) begin
    if (check_en && rst_n) begin
      checkOutput("model_rom_addr", 64'(rom_addr), 64'(mpc));
      checkOutput("model_valid", 64'(instr_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        checkOutput("model_instr", 64'(instr), 64'(mq[0].data));
        checkOutput("model_instr_pc", 64'(instr_pc), 64'(mq[0].pc));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    waitNeg(3);
    rst_n    = 1'b1;
    check_en = 1'b1;

    // Reset with fetch disabled: nothing ever becomes valid
    waitNeg(3);
    checkOutput("reset_rom_addr", 64'(rom_addr), 64'd0);
    checkOutput("reset_valid", 64'(instr_valid), 64'd0);
    checkOutput("reset_instr", 64'(instr), 64'd0);
    checkOutput("reset_instr_pc", 64'(instr_pc), 64'd0);

    // Straight-line fetch: two-edge start-up, then one word per cycle
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    waitNeg(1);
    checkOutput("start_valid_early", 64'(instr_valid), 64'd0);
    waitNeg(1);
    checkHead("start0", 32'h100, 5'd0);
    waitNeg(1);
    checkHead("start1", 32'h101, 5'd1);
    waitNeg(1);
    checkHead("start2", 32'h102, 5'd2);

    // Backpressure from a fresh start at PC 0
    applyStimulus(1'b1, 1'b1, 5'd0, 1'b0);
    waitNeg(1);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkOutput("bp_flush_valid", 64'(instr_valid), 64'd0);
    checkOutput("bp_flush_rom_addr", 64'(rom_addr), 64'd0);
    waitNeg(4);
    checkHead("bp_hold", 32'h100, 5'd0);
    checkOutput("bp_rom_addr_frozen", 64'(rom_addr), 64'd2);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    waitNeg(1);
    checkHead("bp_rel1", 32'h101, 5'd1);
    waitNeg(1);
    checkHead("bp_rel2", 32'h102, 5'd2);
    waitNeg(1);
    checkHead("bp_rel3", 32'h103, 5'd3);

    // Wrap-around past the top of the address space
    applyStimulus(1'b1, 1'b1, 5'd30, 1'b1);
    waitNeg(1);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    checkOutput("wrap_flush_valid", 64'(instr_valid), 64'd0);
    checkOutput("wrap_rom_addr", 64'(rom_addr), 64'd30);
    checkOutput("wrap_head_zero_instr", 64'(instr), 64'd0);
    checkOutput("wrap_head_zero_pc", 64'(instr_pc), 64'd0);
    waitNeg(1);
    checkHead("wrap30", 32'h11E, 5'd30);
    waitNeg(1);
    checkHead("wrap31", 32'h11F, 5'd31);
    waitNeg(1);
    checkHead("wrap0", 32'h100, 5'd0);
    waitNeg(1);
    checkHead("wrap1", 32'h101, 5'd1);

    // Redirect while full with ready high: no pop, flush, then target
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    waitNeg(3);
    checkOutput("full_valid", 64'(instr_valid), 64'd1);
    applyStimulus(1'b1, 1'b1, 5'd12, 1'b1);
    waitNeg(1);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    checkOutput("redir_valid", 64'(instr_valid), 64'd0);
    checkOutput("redir_rom_addr", 64'(rom_addr), 64'd12);
    waitNeg(1);
    checkHead("redir12", 32'h10C, 5'd12);
    waitNeg(1);
    checkHead("redir13", 32'h10D, 5'd13);

    // Asynchronous reset mid-run with a full buffer
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    waitNeg(3);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(instr_valid), 64'd0);
    checkOutput("arst_rom_addr", 64'(rom_addr), 64'd0);
    checkOutput("arst_instr", 64'(instr), 64'd0);
    checkOutput("arst_instr_pc", 64'(instr_pc), 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    waitNeg(3);
    checkOutput("arst_idle_rom_addr", 64'(rom_addr), 64'd0);
    checkOutput("arst_idle_valid", 64'(instr_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    waitNeg(1);
    checkOutput("arst_restart_early", 64'(instr_valid), 64'd0);
    checkOutput("arst_restart_addr", 64'(rom_addr), 64'd0);
    waitNeg(1);
    checkHead("arst_restart", 32'h100, 5'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit fe;
      bit rv;
      bit rdy;
      fe  = ($urandom_range(0, 99) < 85);
      rv  = !redirect_valid && ($urandom_range(0, 99) < 8);
      rdy = ($urandom_range(0, 99) < 60);
      applyStimulus(fe, rv, BITS_ADDR'($urandom), rdy);
      waitNeg(1);
    end

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Instruction-fetch controller for the combinational program ROM. It owns the program counter and drives the ROM address every cycle, then captures the returned instruction word together with its PC into a 2-entry output buffer. It presents each word to the decode stage through a valid/ready handshake. It sits between the program ROM and the decoder, and accepts control-flow redirects (branch/jump targets) from the execute stage.

## Interface
Parameters
- BITS_DATA, 32, instruction width; must match the ROM data width
- BITS_ADDR, 5, PC/ROM address width; the ROM depth is 2**BITS_ADDR
- RESET_PC, 0, PC value loaded at reset

Ports
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_en  in  1  level enable; 1 = fetch, 0 = stop fetching
- redirect_valid  in  1  one-cycle pulse that loads a new PC and flushes the buffer
- redirect_addr  in  BITS_ADDR  target PC, used when redirect_valid=1
- rom_addr  out  BITS_ADDR  address to the ROM, driven directly from the PC register
- rom_data  in  BITS_DATA  ROM output word for rom_addr, valid in the same cycle
- instr_valid  out  1  buffer head holds a valid instruction
- instr_ready  in  1  decoder accepts the head this cycle
- instr  out  BITS_DATA  head instruction word
- instr_pc  out  BITS_ADDR  PC of the head instruction

## Operation
- FSM states:
  - IDLE (reset state) → RUN when fetch_en=1 is sampled.
  - RUN → IDLE when fetch_en=0 is sampled.
  - redirect_valid does not change the state.
- pop = instr_valid & instr_ready.
- capture = (state==RUN) & ~redirect_valid & (count<2 | pop).
- On capture:
  - write {rom_data, pc} at the buffer tail.
  - pc ← pc+1, modulo 2**BITS_ADDR (2**BITS_ADDR−1 wraps to 0, no flag).
- No capture → pc holds.
- count ← count + capture − pop; count is in the range 0..2.
- Buffer: 2-entry FIFO.
  - instr and instr_pc are driven from head registers, so outputs are registered with no combinational path from rom_data.
  - instr_valid = (count≠0).
- Redirect (highest priority, either state):
  - pc ← redirect_addr.
  - count ← 0; the buffer is flushed and head registers are zeroed.
  - No capture and no pop that cycle, even if instr_ready=1. The decoder must treat the flushed head as not consumed.
- fetch_en falling: fetching stops, and entries already buffered keep draining normally.
- Handshake:
  - Once instr_valid=1, instr and instr_pc are held stable until pop or redirect.
  - instr_valid never drops without pop or redirect.
- Reset values:
  - pc=RESET_PC, so rom_addr=RESET_PC.
  - state=IDLE, count=0.
  - instr_valid=0, instr=0, instr_pc=0.
- Reset mid-operation: asynchronous; all of the above take effect immediately. Buffered instructions are discarded.

## Timing
- Start-up: fetch_en sampled high at edge k → RUN after k → rom_addr=RESET_PC during cycle k+1 → captured at edge k+1. instr_valid=1 after edge k+1, a 2-edge latency.
- Steady state: with instr_ready held at 1, one instruction per cycle and instr_pc increments by 1 every cycle.
- Backpressure: with instr_ready=0, the buffer fills within 2 captures, then pc freezes. Releasing ready resumes at 1 per cycle with no bubble, because a pop allows a capture in the same cycle.
- Redirect asserted in cycle r: rom_addr=redirect_addr in cycle r+1, instr_valid=0 in cycle r+1, and the target instruction is valid at cycle r+2. Penalty: 1 bubble after the flush cycle.
- Redirect and fetch_en=0 sampled together: pc is loaded, the buffer is flushed, state goes to IDLE.
- ROM read is combinational: rom_data must settle within the same cycle as rom_addr.

## Test plan
- Reset with ROM word[i]=i+0x100: after rst_n release with fetch_en=0 → rom_addr=0 and instr_valid=0 indefinitely.
- Straight-line fetch: fetch_en=1, instr_ready=1 → first instr_valid 2 edges later with instr=0x100, instr_pc=0. Then 0x101/1, 0x102/2 … on consecutive cycles, with no gaps.
- Backpressure: instr_ready=0 for 5 cycles from start → count saturates at 2, head holds 0x100/0 stable, rom_addr freezes at 2. Releasing ready delivers PCs 0,1,2,3 on consecutive cycles.
- Wrap-around with BITS_ADDR=5, redirect to 30 → the sequence delivers instr_pc 30, 31, 0, 1 with words 0x11E, 0x11F, 0x100, 0x101.
- Redirect to 12 while count=2 and instr_ready=1 in the same cycle → no pop counted, instr_valid=0 next cycle, next delivered instruction 0x10C/12, then 0x10D/13.
- Reset mid-run: rst_n pulsed low for half a cycle while count=2 → instr_valid=0 immediately. After release, rom_addr=RESET_PC and the state is IDLE until fetch_en is re-sampled high.
